// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Bundles the hazard-detection inputs and the pipeline-control outputs of
// pipe_hazard_ctrl.
//   master : pipeline side, drives hazard sources, receives enables/flushes
//   slave  : the controller itself
// Signals:
//   ID_RS/ID_RT/ID_USES_RT        source operands of the ID instruction
//   EX_MEM_READ/EX_RD             load in EX and its destination
//   EX_BRANCH_TAKEN               taken branch/jump resolved in EX
//   MEM_REQ/DM_READY              data-memory access handshake
//   PC_EN..MEM_WB_BUBBLE          per-stage load enables and flush/bubble
//   DM_REQ/DM_ERR                 memory request and sticky timeout error
//   STALL_CNT                     saturating count of cycles with PC_EN=0
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_RS;
    logic [4:0]       ID_RT;
    logic             ID_USES_RT;
    logic             EX_MEM_READ;
    logic [4:0]       EX_RD;
    logic             EX_BRANCH_TAKEN;
    logic             MEM_REQ;
    logic             DM_READY;
    logic             PC_EN;
    logic             IF_ID_EN;
    logic             IF_ID_FLUSH;
    logic             ID_EX_EN;
    logic             ID_EX_FLUSH;
    logic             EX_MEM_EN;
    logic             MEM_WB_BUBBLE;
    logic             DM_REQ;
    logic             DM_ERR;
    logic [CNT_W-1:0] STALL_CNT;

    modport master (
        output ID_RS, ID_RT, ID_USES_RT, EX_MEM_READ, EX_RD,
               EX_BRANCH_TAKEN, MEM_REQ, DM_READY,
        input  PC_EN, IF_ID_EN, IF_ID_FLUSH, ID_EX_EN, ID_EX_FLUSH,
               EX_MEM_EN, MEM_WB_BUBBLE, DM_REQ, DM_ERR, STALL_CNT
    );

    modport slave (
        input  ID_RS, ID_RT, ID_USES_RT, EX_MEM_READ, EX_RD,
               EX_BRANCH_TAKEN, MEM_REQ, DM_READY,
        output PC_EN, IF_ID_EN, IF_ID_FLUSH, ID_EX_EN, ID_EX_FLUSH,
               EX_MEM_EN, MEM_WB_BUBBLE, DM_REQ, DM_ERR, STALL_CNT
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush controller for the 5-stage pipeline. Resolves, in
// priority order: data-memory wait (full freeze), taken branch in EX
// (flush IF_ID and ID_EX), and load-use (hold PC/IF_ID, bubble ID_EX).
// A watchdog moves the memory FSM to a permanent ERR state when DM_READY
// does not arrive within TIMEOUT_CYC wait cycles.
// Ports:
//   clk    pipeline clock
//   rst_n  asynchronous active-low reset
//   hz     pipe_hazard_ctrl_if.slave (hazard inputs, stage controls,
//          DM_REQ/DM_ERR, STALL_CNT)
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ERR  = 2'd2;

    localparam int                WCNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(TIMEOUT_CYC);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]        state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic              mem_stall;
    logic              dm_req;
    logic              load_use;
    logic              pc_en, if_id_en, if_id_flush;
    logic              id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble;

    // Memory handshake FSM. DM_READY is only looked at in WAIT, so the
    // minimum memory latency is one cycle after the request appears.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_stall    = 1'b0;
        dm_req       = 1'b0;
        case (state)
            IDLE: begin
                if (hz.MEM_REQ) begin
                    dm_req       = 1'b1;
                    mem_stall    = 1'b1;
                    state_nxt    = WAIT;
                    wait_cnt_nxt = WCNT_W'(1);
                end
            end
            WAIT: begin
                dm_req = 1'b1;
                if (hz.DM_READY) begin
                    // release: the pipeline advances on this very edge
                    state_nxt = IDLE;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt >= WAIT_MAX) begin
                        state_nxt = ERR;
                    end else begin
                        wait_cnt_nxt = wait_cnt + WCNT_W'(1);
                    end
                end
            end
            ERR: begin
                mem_stall = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign load_use = hz.EX_MEM_READ && (hz.EX_RD != 5'd0) &&
                      ((hz.EX_RD == hz.ID_RS) ||
                       (hz.ID_USES_RT && (hz.EX_RD == hz.ID_RT)));

    // A memory freeze holds any pending branch/load-use in place; they are
    // re-evaluated once the freeze lifts. A taken branch wins over load-use
    // because the ID instruction is on the wrong path.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        if (mem_stall) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (hz.EX_BRANCH_TAKEN) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (!pc_en) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    // Controls are forced low while reset is asserted, so an access in
    // flight is abandoned without waiting for a clock edge.
    assign hz.PC_EN         = rst_n & pc_en;
    assign hz.IF_ID_EN      = rst_n & if_id_en;
    assign hz.IF_ID_FLUSH   = rst_n & if_id_flush;
    assign hz.ID_EX_EN      = rst_n & id_ex_en;
    assign hz.ID_EX_FLUSH   = rst_n & id_ex_flush;
    assign hz.EX_MEM_EN     = rst_n & ex_mem_en;
    assign hz.MEM_WB_BUBBLE = rst_n & mem_wb_bubble;
    assign hz.DM_REQ        = rst_n & dm_req;
    // ERR is only left through reset, which makes the error sticky
    assign hz.DM_ERR        = (state == ERR);
    assign hz.STALL_CNT     = stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives enable and flush/bubble controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Resolves three hazard sources: load-use, taken branch in EX, and a variable-latency data-memory handshake, which has a timeout watchdog.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- TIMEOUT_CYC, 64, max WAIT cycles without DM_READY before entering ERR (must be >=2).
- CNT_W, 16, width of STALL_CNT.

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ID_RS  in  5  rs field of instruction in ID
- ID_RT  in  5  rt field of instruction in ID
- ID_USES_RT  in  1  ID instruction reads rt as a source
- EX_MEM_READ  in  1  instruction in EX is a load
- EX_RD  in  5  destination register of instruction in EX
- EX_BRANCH_TAKEN  in  1  branch/jump resolved taken in EX
- MEM_REQ  in  1  instruction in MEM accesses data memory
- DM_READY  in  1  data memory completes the access (sampled only in WAIT)
- PC_EN  out  1  PC update enable
- IF_ID_EN  out  1  IF_ID load enable
- IF_ID_FLUSH  out  1  IF_ID loads NOP
- ID_EX_EN  out  1  ID_EX load enable
- ID_EX_FLUSH  out  1  ID_EX loads bubble (all control zero)
- EX_MEM_EN  out  1  EX_MEM load enable
- MEM_WB_BUBBLE  out  1  MEM_WB loads bubble (WB_RF_D_SEL=0, no RF write); MEM_WB itself always clocks
- DM_REQ  out  1  data memory request
- DM_ERR  out  1  sticky memory timeout error
- STALL_CNT  out  CNT_W  cycles with PC_EN=0, saturating

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, wait counter=0, STALL_CNT=0, DM_ERR=0.
  - All enables, flushes, DM_REQ and MEM_WB_BUBBLE held 0 while rst_n=0.
  - Reset mid-WAIT abandons the access; DM_REQ drops immediately.
- FSM states: IDLE, WAIT, ERR.
  - IDLE: if MEM_REQ=1 then DM_REQ=1, mem_stall=1, next=WAIT, wait counter cleared to 1. DM_READY is ignored in IDLE, so memory latency is at least 1 cycle.
  - WAIT: DM_REQ=1.
    - DM_READY=1: mem_stall=0 this cycle so the pipeline advances at this edge; next=IDLE.
    - Otherwise mem_stall=1 and the counter increments. When the counter reaches TIMEOUT_CYC, next=ERR.
  - ERR: DM_REQ=0, DM_ERR=1, mem_stall=1 permanently until reset.
- Output priority, combinational from state and inputs:
  - 1) mem_stall=1:
    - PC_EN=IF_ID_EN=ID_EX_EN=EX_MEM_EN=0, MEM_WB_BUBBLE=1.
    - All flushes=0. A pending branch or load-use stays held in place and is re-evaluated after release.
  - 2) EX_BRANCH_TAKEN=1:
    - IF_ID_FLUSH=1, ID_EX_FLUSH=1, all enables=1, MEM_WB_BUBBLE=0.
    - Load-use is suppressed because the ID instruction is wrong-path.
  - 3) load_use:
    - Condition: EX_MEM_READ and EX_RD!=0 and (EX_RD==ID_RS or (ID_USES_RT and EX_RD==ID_RT)).
    - PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, EX_MEM_EN=1, ID_EX_EN=1, MEM_WB_BUBBLE=0.
  - 4) else: all enables=1, all flushes=0, MEM_WB_BUBBLE=0.
- STALL_CNT:
  - Increments at each edge where PC_EN=0 and rst_n=1.
  - Holds at 2^CNT_W-1 once saturated.
- Back-to-back memory ops: after the DM_READY cycle the FSM returns to IDLE. A new MEM_REQ in the next cycle starts a new WAIT; there is no idle gap requirement.

Test Plan:
- Reset, then no hazards for 10 cycles -> all enables=1, flushes=0, DM_REQ=0, STALL_CNT=0.
- EX_MEM_READ=1, EX_RD=5, ID_RS=5 for 1 cycle -> PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, STALL_CNT=1. Repeat with EX_RD=0 -> no stall. Repeat with ID_RT=5, ID_USES_RT=0 -> no stall.
- Load-use and EX_BRANCH_TAKEN in the same cycle -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_EN=1, STALL_CNT unchanged.
- MEM_REQ=1, DM_READY rises 3 cycles later -> DM_REQ=1 for 4 cycles. Freeze with MEM_WB_BUBBLE=1 for 3 cycles, release on the 4th. STALL_CNT=3. EX_BRANCH_TAKEN held during the freeze flushes only in the release cycle.
- TIMEOUT_CYC=4, MEM_REQ=1, DM_READY=0 -> ERR after 4 WAIT cycles: DM_ERR=1, DM_REQ=0, pipeline frozen. Apply rst_n=0 -> DM_ERR=0, state IDLE.
- CNT_W=4 with a 20-cycle memory stall -> STALL_CNT saturates at 15. Async reset asserted mid-WAIT -> DM_REQ drops without waiting for a clock edge.
